alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Single-issue ALU front end: decodes ADD/SUB/ADDI (and BEQ/BNE when
// ALU_ISSUE_BRANCH_EN is defined), drives an external ALU and reports the outcome.
package alu_issue_pkg;
    localparam int DATA_W = 32;
    typedef logic [DATA_W-1:0] t_data;
    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'd0,
        ALU_OP_SUB = 2'd1
    } t_alu_operation;
endpackage

module alu_issue
    import alu_issue_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_instr_valid,
    output logic           o_instr_ready,
    input  logic [31:0]    i_instr,
    input  t_data          i_pc,
    output logic [4:0]     o_rs1_addr,
    output logic [4:0]     o_rs2_addr,
    input  t_data          i_rs1_data,
    input  t_data          i_rs2_data,
    output t_alu_operation o_alu_operation,
    output t_data          o_alu_operand1,
    output t_data          o_alu_operand2,
    input  t_data          i_alu_result,
    input  logic           i_alu_zero,
    output logic           o_wb_valid,
    output logic [4:0]     o_wb_rd,
    output t_data          o_wb_data,
    output logic           o_branch_valid,
    output logic           o_branch_taken,
    output t_data          o_branch_target,
    output logic           o_illegal,
    input  logic           i_flush
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, EXECUTE, WRITEBACK} t_state;
    typedef enum logic [1:0] {K_ALU, K_BRANCH, K_ILLEGAL} t_kind;

    function automatic t_data sext_i(input logic [31:0] ins);
        return {{(DATA_W-12){ins[31]}}, ins[31:20]};
    endfunction

    function automatic t_data sext_b(input logic [31:0] ins);
        return {{(DATA_W-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    t_state         state;
    t_kind          dec_kind;
    t_alu_operation dec_op;
    t_data          dec_a;
    t_data          dec_b;
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;

    t_kind          kind_p0;
    logic [4:0]     rd_p0;
    logic           wb_pulse_p1;
    logic           br_pulse_p1;
    logic           ill_pulse_p1;

    assign opcode     = i_instr[6:0];
    assign funct3     = i_instr[14:12];
    assign funct7     = i_instr[31:25];
    assign o_rs1_addr = i_instr[19:15];
    assign o_rs2_addr = i_instr[24:20];

    assign o_instr_ready = (state == IDLE) && !i_flush;

    always_comb begin
        dec_kind = K_ILLEGAL;
        dec_op   = ALU_OP_ADD;
        dec_a    = '0;
        dec_b    = '0;
        if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == 7'b0000000) begin
            dec_kind = K_ALU;
            dec_a    = i_rs1_data;
            dec_b    = i_rs2_data;
        end else if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == 7'b0100000) begin
            dec_kind = K_ALU;
            dec_op   = ALU_OP_SUB;
            dec_a    = i_rs1_data;
            dec_b    = i_rs2_data;
        end else if (opcode == OPC_OP_IMM && funct3 == 3'b000) begin
            dec_kind = K_ALU;
            dec_a    = i_rs1_data;
            dec_b    = sext_i(i_instr);
        end
`ifdef ALU_ISSUE_BRANCH_EN
        else if (opcode == OPC_BRANCH && (funct3 == 3'b000 || funct3 == 3'b001)) begin
            dec_kind = K_BRANCH;
            dec_op   = ALU_OP_SUB;
            dec_a    = i_rs1_data;
            dec_b    = i_rs2_data;
        end
`endif
    end

`ifdef ALU_ISSUE_BRANCH_EN
    logic  bne_p0;
    t_data target_p0;
    logic  br_taken_p1;
    t_data br_target_p1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bne_p0       <= 1'b0;
            target_p0    <= '0;
            br_taken_p1  <= 1'b0;
            br_target_p1 <= '0;
        end else if (!i_flush) begin
            if (state == IDLE && i_instr_valid) begin
                bne_p0    <= funct3[0];
                // Target adder is separate from the ALU, which is busy comparing rs1/rs2.
                target_p0 <= i_pc + sext_b(i_instr);
            end else if (state == EXECUTE && kind_p0 == K_BRANCH) begin
                br_taken_p1  <= bne_p0 ? !i_alu_zero : i_alu_zero;
                br_target_p1 <= target_p0;
            end
        end
    end

    assign o_branch_valid  = br_pulse_p1 && !i_flush;
    assign o_branch_taken  = br_taken_p1;
    assign o_branch_target = br_target_p1;
`else
    logic unused_branch;
    assign unused_branch   = ^{i_pc, i_alu_zero, br_pulse_p1};
    assign o_branch_valid  = 1'b0;
    assign o_branch_taken  = 1'b0;
    assign o_branch_target = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            kind_p0         <= K_ALU;
            rd_p0           <= '0;
            o_alu_operation <= ALU_OP_ADD;
            o_alu_operand1  <= '0;
            o_alu_operand2  <= '0;
            wb_pulse_p1     <= 1'b0;
            br_pulse_p1     <= 1'b0;
            ill_pulse_p1    <= 1'b0;
            o_wb_rd         <= '0;
            o_wb_data       <= '0;
        end else begin
            wb_pulse_p1  <= 1'b0;
            br_pulse_p1  <= 1'b0;
            ill_pulse_p1 <= 1'b0;
            if (i_flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    // Stage p0: accept and decode.
                    IDLE: begin
                        if (i_instr_valid) begin
                            state           <= EXECUTE;
                            kind_p0         <= dec_kind;
                            rd_p0           <= i_instr[11:7];
                            o_alu_operation <= dec_op;
                            o_alu_operand1  <= dec_a;
                            o_alu_operand2  <= dec_b;
                        end
                    end
                    // Stage p1: sample the ALU and arm the outcome pulse.
                    EXECUTE: begin
                        state <= WRITEBACK;
                        case (kind_p0)
                            K_ALU: begin
                                if (rd_p0 != 5'd0) begin
                                    wb_pulse_p1 <= 1'b1;
                                    o_wb_rd     <= rd_p0;
                                    o_wb_data   <= i_alu_result;
                                end
                            end
                            K_BRANCH: br_pulse_p1  <= 1'b1;
                            default:  ill_pulse_p1 <= 1'b1;
                        endcase
                    end
                    WRITEBACK: state <= IDLE;
                    default:   state <= IDLE;
                endcase
            end
        end
    end

    assign o_wb_valid = wb_pulse_p1 && !i_flush;
    assign o_illegal  = ill_pulse_p1 && !i_flush;

endmodule
